// File: rtl/cheshire_eoc_monitor.sv
// End-of-computation monitor: snoops register-bus writes to the EOC scratch register and reports exit status.
// Optional watchdog is built when CHESHIRE_EOC_WATCHDOG_EN is defined.
module cheshire_eoc_monitor #(
  parameter int unsigned          AddrWidth     = 48,
  parameter int unsigned          DataWidth     = 32,
  // Default is the Cheshire scratch register base ('h0300_0000) plus 4.
  parameter logic [AddrWidth-1:0] EocAddr       = AddrWidth'('h0300_0004),
  parameter logic [31:0]          TimeoutCycles = 32'd0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   reg_valid_i,
  input  logic                   reg_ready_i,
  input  logic                   reg_write_i,
  input  logic [AddrWidth-1:0]   reg_addr_i,
  input  logic [DataWidth-1:0]   reg_wdata_i,
  input  logic [DataWidth/8-1:0] reg_wstrb_i,
  output logic                   busy_o,
  output logic                   eoc_o,
  output logic                   pass_o,
  output logic [30:0]            exit_code_o,
  output logic                   timeout_o,
  output logic [31:0]            cycles_o
);

  typedef enum logic [1:0] {IDLE, ARMED, DONE, TIMEOUT} state_e;

  state_e      state_q;
  logic [31:0] shadow_q;
  logic [31:0] cycles_q;
  logic [31:0] cycles_inc;
  logic [31:0] merged;
  logic        hit;
  logic        busy_q;
  logic        eoc_q;
  logic        pass_q;
  logic [30:0] exit_code_q;
  logic        expired;

  assign hit        = reg_valid_i & reg_ready_i & reg_write_i & (reg_addr_i == EocAddr);
  assign cycles_inc = (cycles_q == 32'hFFFF_FFFF) ? cycles_q : cycles_q + 32'd1;

  always_comb begin
    merged = shadow_q;
    for (int b = 0; b < 4; b++) begin
      if (reg_wstrb_i[b]) merged[8*b +: 8] = reg_wdata_i[8*b +: 8];
    end
  end

`ifdef CHESHIRE_EOC_WATCHDOG_EN
  logic timeout_q;
  assign expired   = (TimeoutCycles != 32'd0) && (cycles_inc == TimeoutCycles);
  assign timeout_o = timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TimeoutCycles;
  assign expired        = 1'b0;
  assign timeout_o      = 1'b0;
`endif

  // A start pulse overrides everything, including a simultaneous hit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      cycles_q    <= '0;
      busy_q      <= 1'b0;
      eoc_q       <= 1'b0;
      pass_q      <= 1'b0;
      exit_code_q <= '0;
`ifdef CHESHIRE_EOC_WATCHDOG_EN
      timeout_q   <= 1'b0;
`endif
    end else if (start_i) begin
      state_q     <= ARMED;
      shadow_q    <= '0;
      cycles_q    <= '0;
      busy_q      <= 1'b1;
      eoc_q       <= 1'b0;
      pass_q      <= 1'b0;
      exit_code_q <= '0;
`ifdef CHESHIRE_EOC_WATCHDOG_EN
      timeout_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ARMED: begin
          cycles_q <= cycles_inc;
          if (hit) shadow_q <= merged;
          // Completion takes priority over a same-cycle watchdog expiry.
          if (hit && merged[0]) begin
            state_q     <= DONE;
            busy_q      <= 1'b0;
            eoc_q       <= 1'b1;
            pass_q      <= (merged[31:1] == 31'd0);
            exit_code_q <= merged[31:1];
          end else if (expired) begin
            state_q   <= TIMEOUT;
            busy_q    <= 1'b0;
`ifdef CHESHIRE_EOC_WATCHDOG_EN
            timeout_q <= 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign eoc_o       = eoc_q;
  assign pass_o      = pass_q;
  assign exit_code_o = exit_code_q;
  assign cycles_o    = cycles_q;

endmodule
